mem_port_arbiter: RTL and testbench

Shares the single memory port between the IF stage instruction fetch path and the MEM stage load/store path. It sequences one outstanding transaction at a time through a request/grant/response handshake. Data requests have fixed priority, with a starvation counter that guarantees forward progress for fetch. It also discards in-flight fetch responses when the decode stage flushes.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory handshake signals shared by the
// arbiter (slave view) and whatever drives it (master view).
interface mem_port_arbiter_if;
    logic        flush_en_ip;

    logic        instr_req_ip;
    logic [31:0] instr_addr_ip;
    logic        instr_gnt_op;
    logic        instr_rvalid_op;
    logic [31:0] instr_rdata_op;

    logic        data_req_ip;
    logic        data_we_ip;
    logic [3:0]  data_be_ip;
    logic [31:0] data_addr_ip;
    logic [31:0] data_wdata_ip;
    logic        data_gnt_op;
    logic        data_rvalid_op;
    logic [31:0] data_rdata_op;

    logic        mem_req_op;
    logic        mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op;
    logic [31:0] mem_wdata_op;
    logic        mem_gnt_ip;
    logic        mem_rvalid_ip;
    logic [31:0] mem_rdata_ip;

    modport slave (
        input  flush_en_ip,
        input  instr_req_ip, instr_addr_ip,
        output instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        output data_gnt_op, data_rvalid_op, data_rdata_op,
        output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip
    );

    modport master (
        output flush_en_ip,
        output instr_req_ip, instr_addr_ip,
        input  instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        input  data_gnt_op, data_rvalid_op, data_rdata_op,
        input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and load/store, with data priority, fetch anti-starvation and flush discard.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    owner_t      r_owner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_be;
    logic [3:0]  r_starve_cnt;
    logic        r_discard;
    logic        r_instr_rvalid;
    logic        r_data_rvalid;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;

    logic w_both;
    logic w_instr_wins;
    logic w_data_wins;
    logic w_grant;
    logic w_flush_hit;

    assign w_both       = bus.instr_req_ip & bus.data_req_ip;
    assign w_instr_wins = bus.instr_req_ip & (~bus.data_req_ip | (r_starve_cnt == LP_STARVE_LIMIT));
    assign w_data_wins  = bus.data_req_ip & ~w_instr_wins;
    assign w_grant      = (r_state == ST_REQ) & bus.mem_gnt_ip;
    assign w_flush_hit  = bus.flush_en_ip & (r_owner == OWN_INSTR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_INSTR;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_be           <= '0;
            r_starve_cnt   <= '0;
            r_discard      <= 1'b0;
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_instr_rdata  <= '0;
            r_data_rdata   <= '0;
        end else begin
            // NOTE: pulse outputs default low here; a later assignment in the same block overrides it.
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_instr_wins) begin
                        r_owner      <= OWN_INSTR;
                        r_addr       <= bus.instr_addr_ip;
                        r_we         <= 1'b0;
                        r_be         <= 4'hF;
                        r_wdata      <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= ST_REQ;
                    end else if (w_data_wins) begin
                        r_owner <= OWN_DATA;
                        r_addr  <= bus.data_addr_ip;
                        r_we    <= bus.data_we_ip;
                        r_be    <= bus.data_be_ip;
                        r_wdata <= bus.data_wdata_ip;
                        if (w_both) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_flush_hit) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.mem_gnt_ip) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_flush_hit) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.mem_rvalid_ip) begin
                        // A flush arriving with the response still drops it.
                        if (r_owner == OWN_INSTR) begin
                            if (!(r_discard | bus.flush_en_ip)) begin
                                r_instr_rvalid <= 1'b1;
                                r_instr_rdata  <= bus.mem_rdata_ip;
                            end
                        end else begin
                            r_data_rvalid <= 1'b1;
                            r_data_rdata  <= r_we ? 32'd0 : bus.mem_rdata_ip;
                        end
                        r_discard <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grant pulses follow mem_gnt_ip in the same cycle so the requester can
    // move on as soon as memory accepts.
    assign bus.instr_gnt_op    = w_grant & (r_owner == OWN_INSTR);
    assign bus.data_gnt_op     = w_grant & (r_owner == OWN_DATA);
    assign bus.instr_rvalid_op = r_instr_rvalid;
    assign bus.instr_rdata_op  = r_instr_rdata;
    assign bus.data_rvalid_op  = r_data_rvalid;
    assign bus.data_rdata_op   = r_data_rdata;

    assign bus.mem_req_op   = (r_state == ST_REQ);
    assign bus.mem_we_op    = r_we;
    assign bus.mem_be_op    = r_be;
    assign bus.mem_addr_op  = r_addr;
    assign bus.mem_wdata_op = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the
// memory; expected response data is queued when memory responds and popped on rvalid_op.
module tb_mem_port_arbiter;
    logic clock;
    logic reset;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every rvalid_op pulse must match a queued expectation.
    always @(negedge clock) begin
        if (bus.instr_rvalid_op === 1'b1) begin
            check1("instr_rvalid_expected", exp_instr_q.size() != 0, 1'b1);
            if (exp_instr_q.size() != 0) check("instr_rdata", bus.instr_rdata_op, exp_instr_q.pop_front());
        end
        if (bus.data_rvalid_op === 1'b1) begin
            check1("data_rvalid_expected", exp_data_q.size() != 0, 1'b1);
            if (exp_data_q.size() != 0) check("data_rdata", bus.data_rdata_op, exp_data_q.pop_front());
        end
    end

    // Plays memory for one transaction; entered at posedge+1 of the cycle the
    // request is presented, returns at posedge+1 of the cycle after rvalid.
    task automatic serve(input bit is_instr, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata, input int gdly,
                         input int rdly, input logic [31:0] rdata, input int flush_at,
                         input bit release_req, output int lat);
        int n;
        n = 0;
        while (bus.mem_req_op !== 1'b1 && n < 30) begin
            @(posedge clock); #1;
            bus.flush_en_ip = 1'b0;
            n++;
        end
        lat = n;
        check1("req_raised", bus.mem_req_op, 1'b1);
        for (int i = 0; i <= gdly; i++) begin
            bus.mem_gnt_ip = (i == gdly);
            @(negedge clock);
            check1("mem_req_high", bus.mem_req_op, 1'b1);
            check("mem_addr", bus.mem_addr_op, addr);
            check1("mem_we", bus.mem_we_op, we);
            check("mem_be", 32'(bus.mem_be_op), 32'(be));
            if (!is_instr) check("mem_wdata", bus.mem_wdata_op, wdata);
            check1("instr_gnt", bus.instr_gnt_op, (i == gdly) && is_instr);
            check1("data_gnt", bus.data_gnt_op, (i == gdly) && !is_instr);
            @(posedge clock); #1;
        end
        // gnt left high in WAIT: it must be ignored there
        if (release_req) begin
            if (is_instr) bus.instr_req_ip = 1'b0;
            else bus.data_req_ip = 1'b0;
        end
        for (int i = 0; i <= rdly; i++) begin
            bus.flush_en_ip   = (i == flush_at);
            bus.mem_rvalid_ip = (i == rdly);
            bus.mem_rdata_ip  = (i == rdly) ? rdata : 32'hBAD0_0000;
            @(negedge clock);
            check1("wait_req_low", bus.mem_req_op, 1'b0);
            check1("wait_no_gnt", bus.instr_gnt_op | bus.data_gnt_op, 1'b0);
            @(posedge clock); #1;
        end
        if (is_instr) begin
            if (flush_at < 0 || flush_at > rdly) exp_instr_q.push_back(rdata);
        end else begin
            exp_data_q.push_back(we ? 32'd0 : rdata);
        end
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_gnt_ip    = 1'b0;
        bus.flush_en_ip   = 1'b0;
    endtask

    initial begin
        int lat;
        bit exp_i;
        reset             = 1'b1;
        bus.flush_en_ip   = 1'b0;
        bus.instr_req_ip  = 1'b0;
        bus.instr_addr_ip = '0;
        bus.data_req_ip   = 1'b0;
        bus.data_we_ip    = 1'b0;
        bus.data_be_ip    = '0;
        bus.data_addr_ip  = '0;
        bus.data_wdata_ip = '0;
        bus.mem_gnt_ip    = 1'b0;
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_rdata_ip  = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check1("rst_mem_req", bus.mem_req_op, 1'b0);
        check("rst_mem_addr", bus.mem_addr_op, 32'd0);
        check1("rst_instr_rvalid", bus.instr_rvalid_op, 1'b0);
        check("rst_data_rdata", bus.data_rdata_op, 32'd0);
        check("rst_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Single fetch at minimum latency
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h100;
        serve(1'b1, 32'h100, 1'b0, 4'hF, 32'd0, 0, 0, 32'hDEAD_BEEF, -1, 1'b1, lat);
        check("fetch_req_latency", 32'(lat), 32'd1);
        check1("fetch_rvalid_cycle3", bus.instr_rvalid_op, 1'b1);
        check("fetch_rdata_cycle3", bus.instr_rdata_op, 32'hDEAD_BEEF);
        check1("fetch_data_rvalid", bus.data_rvalid_op, 1'b0);
        check("fetch_data_rdata", bus.data_rdata_op, 32'd0);

        // Both requesters held: DATA x4, INSTR, DATA x4, INSTR, then DATA alone
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h400;
        bus.data_req_ip   = 1'b1;
        bus.data_we_ip    = 1'b0;
        bus.data_be_ip    = 4'hC;
        bus.data_addr_ip  = 32'h800;
        bus.data_wdata_ip = 32'h77;
        for (int i = 0; i < 11; i++) begin
            exp_i = (i == 4) || (i == 9);
            serve(exp_i, exp_i ? 32'h400 : 32'h800, 1'b0, exp_i ? 4'hF : 4'hC, 32'h77,
                  0, 0, 32'h1000 + 32'(i), -1, i >= 9, lat);
            check("starve_latency", 32'(lat), 32'd1);
            if (i == 3) check("starve_cnt_at_limit", 32'(dut.r_starve_cnt), 32'd4);
            if (exp_i) check("starve_cnt_cleared", 32'(dut.r_starve_cnt), 32'd0);
        end
        check("starve_cnt_hold_single", 32'(dut.r_starve_cnt), 32'd0);

        // Store with a 3-cycle grant delay
        bus.data_req_ip   = 1'b1;
        bus.data_we_ip    = 1'b1;
        bus.data_be_ip    = 4'b0011;
        bus.data_addr_ip  = 32'h2000;
        bus.data_wdata_ip = 32'h1234;
        serve(1'b0, 32'h2000, 1'b1, 4'b0011, 32'h1234, 3, 0, 32'h5555_AAAA, -1, 1'b1, lat);
        check1("store_rvalid", bus.data_rvalid_op, 1'b1);
        check("store_rdata_zero", bus.data_rdata_op, 32'd0);

        // Load with a flush during WAIT: flush does not touch data
        bus.data_req_ip   = 1'b1;
        bus.data_we_ip    = 1'b0;
        bus.data_be_ip    = 4'hF;
        bus.data_addr_ip  = 32'h2400;
        bus.data_wdata_ip = 32'h0;
        serve(1'b0, 32'h2400, 1'b0, 4'hF, 32'h0, 1, 1, 32'h0BAD_F00D, 0, 1'b1, lat);
        check1("load_flush_rvalid", bus.data_rvalid_op, 1'b1);

        // Fetch flushed in WAIT, response two cycles later is discarded
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h180;
        serve(1'b1, 32'h180, 1'b0, 4'hF, 32'd0, 0, 2, 32'h1111_2222, 0, 1'b1, lat);
        check1("flush_no_rvalid", bus.instr_rvalid_op, 1'b0);
        check1("flush_idle", bus.mem_req_op, 1'b0);

        // Flush in the same cycle as the response still suppresses it
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h184;
        serve(1'b1, 32'h184, 1'b0, 4'hF, 32'd0, 0, 1, 32'h3333_4444, 1, 1'b1, lat);
        check1("flush_same_cycle_no_rvalid", bus.instr_rvalid_op, 1'b0);

        // Flush seen in IDLE has no effect on the fetch it arbitrates
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h188;
        bus.flush_en_ip   = 1'b1;
        serve(1'b1, 32'h188, 1'b0, 4'hF, 32'd0, 0, 0, 32'hCAFE_F00D, -1, 1'b1, lat);
        check1("post_flush_fetch_rvalid", bus.instr_rvalid_op, 1'b1);

        // Grant stalled for 10 cycles
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h500;
        serve(1'b1, 32'h500, 1'b0, 4'hF, 32'd0, 10, 0, 32'h0102_0304, -1, 1'b1, lat);
        check1("stall_rvalid", bus.instr_rvalid_op, 1'b1);

        // Reset while a load waits for its response
        bus.data_req_ip  = 1'b1;
        bus.data_we_ip   = 1'b0;
        bus.data_be_ip   = 4'hF;
        bus.data_addr_ip = 32'h3000;
        @(posedge clock); #1;
        check1("rst_wait_req_up", bus.mem_req_op, 1'b1);
        bus.mem_gnt_ip = 1'b1;
        @(negedge clock);
        check1("rst_wait_data_gnt", bus.data_gnt_op, 1'b1);
        @(posedge clock); #1;
        bus.mem_gnt_ip  = 1'b0;
        bus.data_req_ip = 1'b0;
        reset           = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check1("mid_rst_mem_req", bus.mem_req_op, 1'b0);
        check("mid_rst_mem_addr", bus.mem_addr_op, 32'd0);
        check("mid_rst_mem_be", 32'(bus.mem_be_op), 32'd0);
        check("mid_rst_data_rdata", bus.data_rdata_op, 32'd0);
        check("mid_rst_instr_rdata", bus.instr_rdata_op, 32'd0);
        check("mid_rst_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h5A5A_5A5A;
        @(posedge clock); #1;
        bus.mem_rvalid_ip = 1'b0;
        check1("stale_rvalid_ignored", bus.data_rvalid_op, 1'b0);
        check1("stale_rvalid_idle", bus.mem_req_op, 1'b0);
        bus.instr_req_ip  = 1'b1;
        bus.instr_addr_ip = 32'h600;
        serve(1'b1, 32'h600, 1'b0, 4'hF, 32'd0, 0, 0, 32'h6060_6060, -1, 1'b1, lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        check1("post_rst_rvalid", bus.instr_rvalid_op, 1'b1);

        @(posedge clock); #1;
        check("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
        check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
